// File: rtl/cfg_chain_pkg.sv
// Shared types and helpers for the configuration-chain programming controller.
// Holds the controller state encoding and a constant-friendly ceiling log2.
package cfg_chain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SHIFT = 3'd2,
        ST_LATCH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cfg_word_serdes.sv
// Word-wide transmit PISO and receive SIPO for the serial configuration chain.
// Both shift LSB-first; a flush right-aligns a partially received word.
module cfg_word_serdes
    import cfg_chain_pkg::*;
#(
    parameter  int WORD_W = 8,
    localparam int CW     = clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_load_data,
    input  logic              i_shift,
    input  logic              i_din,
    input  logic              i_flush,
    output logic              o_tx_bit,
    output logic              o_word_valid,
    output logic [WORD_W-1:0] o_word
);

    localparam logic [CW-1:0] WORD_W_C = CW'(WORD_W);

    logic [WORD_W-1:0] r_tx;
    logic [WORD_W-1:0] r_rx;
    logic [CW-1:0]     r_rx_cnt;

    logic [WORD_W-1:0] w_rx_shifted;
    logic [CW-1:0]     w_cnt_inc;
    logic [CW-1:0]     w_align;
    logic              w_full;

    // New bits enter at the top so the first-received bit lands in bit 0
    // once a full word has arrived; partial words are shifted down on flush.
    always_comb begin
        w_rx_shifted = {i_din, r_rx[WORD_W-1:1]};
        w_cnt_inc    = r_rx_cnt + CW'(1);
        w_full       = (w_cnt_inc == WORD_W_C);
        w_align      = WORD_W_C - w_cnt_inc;
        o_word       = w_rx_shifted >> w_align;
        o_word_valid = i_shift && (w_full || i_flush);
        o_tx_bit     = r_tx[0];
    end

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_tx     <= '0;
            r_rx     <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (i_load) begin
                r_tx <= i_load_data;
            end else if (i_shift) begin
                r_tx <= i_flush ? '0 : (r_tx >> 1);
            end

            if (i_shift) begin
                if (w_full || i_flush) begin
                    r_rx     <= '0;
                    r_rx_cnt <= '0;
                end else begin
                    r_rx     <= w_rx_shifted;
                    r_rx_cnt <= w_cnt_inc;
                end
            end
        end
    end

endmodule

// File: rtl/cfg_chain_ctrl.sv
// Configuration-chain programming controller: serializes host words into the
// chain head, captures the tail as readback words, and pulses latch at the end.
//
// state | meaning
// IDLE  | waiting for start, chain untouched
// FETCH | s_ready high, waiting for the next host word
// SHIFT | shifting the current word into the chain, one bit per cycle
// LATCH | single-cycle cfg_latch pulse after CHAIN_LEN bits
// DONE  | sticky completion, bit_cnt holds CHAIN_LEN until next start
module cfg_chain_ctrl
    import cfg_chain_pkg::*;
#(
    parameter  int WORD_W    = 8,
    parameter  int CHAIN_LEN = 64,
    localparam int CNT_W     = clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              cfg_shift_en,
    output logic              cfg_dout,
    input  logic              cfg_din,
    output logic              cfg_latch,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_cnt
);

    localparam int LEFT_W = clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0]  CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
    localparam logic [LEFT_W-1:0] WORD_W_C    = LEFT_W'(WORD_W);

    state_t             r_state;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [LEFT_W-1:0]  r_word_left;
    logic               r_s_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_shift_en;
    logic               r_latch;
    logic               r_rd_valid;
    logic [WORD_W-1:0]  r_rd_data;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_bit_cnt_nxt;
    logic [LEFT_W-1:0]  w_left_nxt;
    logic               w_s_ready_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_shift_en_nxt;
    logic               w_latch_nxt;

    logic               w_load;
    logic               w_shift;
    logic               w_flush;
    logic               w_clear;
    logic [CNT_W-1:0]   w_remain;
    logic [CNT_W-1:0]   w_bit_cnt_inc;
    logic [LEFT_W-1:0]  w_word_len;
    logic               w_tx_bit;
    logic               w_word_valid;
    logic [WORD_W-1:0]  w_word;

    // The last word may be shorter than WORD_W when CHAIN_LEN is not a multiple.
    always_comb begin
        w_remain      = CHAIN_LEN_C - r_bit_cnt;
        w_bit_cnt_inc = r_bit_cnt + CNT_W'(1);
        if (int'(w_remain) >= WORD_W) begin
            w_word_len = WORD_W_C;
        end else begin
            w_word_len = LEFT_W'(w_remain);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_left_nxt     = r_word_left;
        w_s_ready_nxt  = 1'b0;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = r_done;
        w_shift_en_nxt = 1'b0;
        w_latch_nxt    = 1'b0;
        w_load         = 1'b0;
        w_shift        = 1'b0;
        w_flush        = 1'b0;
        w_clear        = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt   = ST_FETCH;
                    w_bit_cnt_nxt = '0;
                    w_s_ready_nxt = 1'b1;
                    w_busy_nxt    = 1'b1;
                    w_done_nxt    = 1'b0;
                    w_clear       = 1'b1;
                end
            end
            ST_FETCH: begin
                w_busy_nxt = 1'b1;
                if (s_valid) begin
                    w_load         = 1'b1;
                    w_left_nxt     = w_word_len;
                    w_shift_en_nxt = 1'b1;
                    w_state_nxt    = ST_SHIFT;
                end else begin
                    w_s_ready_nxt = 1'b1;
                end
            end
            ST_SHIFT: begin
                w_busy_nxt    = 1'b1;
                w_shift       = 1'b1;
                w_bit_cnt_nxt = w_bit_cnt_inc;
                w_left_nxt    = r_word_left - LEFT_W'(1);
                if (r_word_left == LEFT_W'(1)) begin
                    if (w_bit_cnt_inc == CHAIN_LEN_C) begin
                        w_flush     = 1'b1;
                        w_latch_nxt = 1'b1;
                        w_state_nxt = ST_LATCH;
                    end else begin
                        w_s_ready_nxt = 1'b1;
                        w_state_nxt   = ST_FETCH;
                    end
                end else begin
                    w_shift_en_nxt = 1'b1;
                end
            end
            ST_LATCH: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_word_left <= '0;
            r_s_ready   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_shift_en  <= 1'b0;
            r_latch     <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_word_left <= w_left_nxt;
            r_s_ready   <= w_s_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_shift_en  <= w_shift_en_nxt;
            r_latch     <= w_latch_nxt;
            r_rd_valid  <= w_word_valid;
            if (w_word_valid) begin
                r_rd_data <= w_word;
            end
        end
    end

    cfg_word_serdes #(
        .WORD_W (WORD_W)
    ) u_serdes (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_clear),
        .i_load       (w_load),
        .i_load_data  (s_data),
        .i_shift      (w_shift),
        .i_din        (cfg_din),
        .i_flush      (w_flush),
        .o_tx_bit     (w_tx_bit),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    assign s_ready      = r_s_ready;
    assign cfg_shift_en = r_shift_en;
    assign cfg_dout     = w_tx_bit;
    assign cfg_latch    = r_latch;
    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign busy         = r_busy;
    assign done         = r_done;
    assign bit_cnt      = r_bit_cnt;

endmodule

// File: tb/tb_cfg_chain_ctrl.sv
// Directed bench for cfg_chain_ctrl: a 64-bit chain instance and a 20-bit
// chain instance, each driving a behavioural shift-register chain model.
module tb_cfg_chain_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       a_start, a_s_valid, a_s_ready, a_shift_en, a_dout, a_din;
    logic       a_latch, a_rd_valid, a_busy, a_done;
    logic [7:0] a_s_data, a_rd_data;
    logic [6:0] a_bit_cnt;

    logic       b_start, b_s_valid, b_s_ready, b_shift_en, b_dout, b_din;
    logic       b_latch, b_rd_valid, b_busy, b_done;
    logic [7:0] b_s_data, b_rd_data;
    logic [4:0] b_bit_cnt;

    cfg_chain_ctrl #(.WORD_W(8), .CHAIN_LEN(64)) u_dut64 (
        .clk(clk), .reset(reset), .start(a_start), .s_data(a_s_data),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .cfg_shift_en(a_shift_en),
        .cfg_dout(a_dout), .cfg_din(a_din), .cfg_latch(a_latch),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .busy(a_busy),
        .done(a_done), .bit_cnt(a_bit_cnt)
    );

    cfg_chain_ctrl #(.WORD_W(8), .CHAIN_LEN(20)) u_dut20 (
        .clk(clk), .reset(reset), .start(b_start), .s_data(b_s_data),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .cfg_shift_en(b_shift_en),
        .cfg_dout(b_dout), .cfg_din(b_din), .cfg_latch(b_latch),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .busy(b_busy),
        .done(b_done), .bit_cnt(b_bit_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int a_gap_err = 0;

    // Chain models: tail is bit 0, head enters at the top on each shift.
    logic [63:0] a_chain;
    logic [19:0] b_chain;
    logic        a_pre = 1'b0, b_pre = 1'b0;
    logic [63:0] a_pre_val = '0;
    logic [19:0] b_pre_val = '0;
    int          a_shifts = 0, a_latches = 0, b_shifts = 0, b_latches = 0;
    logic [7:0]  a_rd_q[$];
    logic [7:0]  b_rd_q[$];

    assign a_din = a_chain[0];
    assign b_din = b_chain[0];

    always @(posedge clk) begin
        if (a_pre) a_chain <= a_pre_val;
        else if (a_shift_en) a_chain <= {a_dout, a_chain[63:1]};
        if (b_pre) b_chain <= b_pre_val;
        else if (b_shift_en) b_chain <= {b_dout, b_chain[19:1]};
        if (a_shift_en) a_shifts++;
        if (b_shift_en) b_shifts++;
        if (a_latch) a_latches++;
        if (b_latch) b_latches++;
        if (a_rd_valid) a_rd_q.push_back(a_rd_data);
        if (b_rd_valid) b_rd_q.push_back(b_rd_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic a_preload(input logic [63:0] v);
        @(negedge clk); a_pre_val = v; a_pre = 1'b1;
        @(negedge clk); a_pre = 1'b0;
    endtask

    task automatic b_preload(input logic [19:0] v);
        @(negedge clk); b_pre_val = v; b_pre = 1'b1;
        @(negedge clk); b_pre = 1'b0;
    endtask

    task automatic a_start_pulse();
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
    endtask

    task automatic a_send(input logic [7:0] w, input int gap);
        int t = 0;
        a_s_data = w;
        if (gap > 0) a_s_valid = 1'b0;
        while (!a_s_ready && t < 200) begin @(negedge clk); t++; end
        n_checks++;
        if (a_s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL a_send_ready: s_ready=%b after %0d cycles, required 1", a_s_ready, t);
        end
        for (int i = 0; i < gap; i++) begin
            if (a_shift_en !== 1'b0 || a_s_ready !== 1'b1) a_gap_err++;
            @(negedge clk);
        end
        a_s_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic a_wait_done();
        int t = 0;
        while (a_done !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
    endtask

    task automatic a_program(input logic [63:0] words, input int gap);
        a_start_pulse();
        for (int i = 0; i < 8; i++) a_send(words[8*i +: 8], gap);
        a_s_valid = 1'b0;
        a_wait_done();
    endtask

    task automatic b_send(input logic [7:0] w);
        int t = 0;
        b_s_data = w;
        while (!b_s_ready && t < 200) begin @(negedge clk); t++; end
        n_checks++;
        if (b_s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b_send_ready: s_ready=%b after %0d cycles, required 1", b_s_ready, t);
        end
        b_s_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_start = 1'b0; a_s_valid = 1'b0; a_s_data = '0;
        b_start = 1'b0; b_s_valid = 1'b0; b_s_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({a_busy, a_done, a_s_ready, a_shift_en, a_latch, a_rd_valid, a_dout} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags64: got %b, required 0000000",
                     {a_busy, a_done, a_s_ready, a_shift_en, a_latch, a_rd_valid, a_dout});
        end
        n_checks++;
        if (a_bit_cnt !== 7'd0 || a_rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_cnt64: bit_cnt=%0d rd_data=%h, required 0 00", a_bit_cnt, a_rd_data);
        end
        n_checks++;
        if ({b_busy, b_done, b_s_ready, b_shift_en, b_latch, b_rd_valid, b_dout} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags20: got %b, required 0000000",
                     {b_busy, b_done, b_s_ready, b_shift_en, b_latch, b_rd_valid, b_dout});
        end
        n_checks++;
        if (b_bit_cnt !== 5'd0 || b_rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_cnt20: bit_cnt=%0d rd_data=%h, required 0 00", b_bit_cnt, b_rd_data);
        end
    endtask

    task automatic test_full_load();
        int s0, l0, r0;
        a_preload(64'h0123_4567_89AB_CDEF);
        s0 = a_shifts; l0 = a_latches; r0 = a_rd_q.size();
        a_program(64'h0807_0605_0403_0201, 0);
        n_checks++;
        if (a_shifts - s0 !== 64) begin
            n_fail++; $display("FAIL full_shifts: got %0d, required 64", a_shifts - s0);
        end
        n_checks++;
        if (a_latches - l0 !== 1) begin
            n_fail++; $display("FAIL full_latch: got %0d pulses, required 1", a_latches - l0);
        end
        n_checks++;
        if (a_done !== 1'b1 || a_busy !== 1'b0 || a_bit_cnt !== 7'd64) begin
            n_fail++;
            $display("FAIL full_status: done=%b busy=%b bit_cnt=%0d, required 1 0 64", a_done, a_busy, a_bit_cnt);
        end
        n_checks++;
        if (a_chain !== 64'h0807_0605_0403_0201) begin
            n_fail++; $display("FAIL full_chain: got %h, required 0807060504030201", a_chain);
        end
        n_checks++;
        if (a_rd_q.size() - r0 !== 8 || a_rd_q[r0] !== 8'hEF || a_rd_q[r0+7] !== 8'h01) begin
            n_fail++;
            $display("FAIL full_readback: count=%0d first=%h last=%h, required 8 ef 01",
                     a_rd_q.size() - r0, a_rd_q[r0], a_rd_q[a_rd_q.size()-1]);
        end
    endtask

    task automatic test_readback();
        int r0, bad;
        a_preload({8{8'hA5}});
        r0 = a_rd_q.size();
        a_program(64'h0, 0);
        bad = 0;
        for (int i = r0; i < a_rd_q.size(); i++) if (a_rd_q[i] !== 8'hA5) bad++;
        n_checks++;
        if (a_rd_q.size() - r0 !== 8 || bad !== 0) begin
            n_fail++;
            $display("FAIL readback_words: count=%0d wrong=%0d, required 8 words of a5 and 0 wrong",
                     a_rd_q.size() - r0, bad);
        end
        n_checks++;
        if (a_chain !== 64'h0) begin
            n_fail++; $display("FAIL readback_chain: got %h, required 0", a_chain);
        end
    endtask

    task automatic test_stall();
        int s0;
        a_gap_err = 0;
        s0 = a_shifts;
        a_program(64'h0807_0605_0403_0201, 5);
        n_checks++;
        if (a_gap_err !== 0) begin
            n_fail++; $display("FAIL stall_gap: %0d gap cycles shifted, required 0", a_gap_err);
        end
        n_checks++;
        if (a_shifts - s0 !== 64 || a_chain !== 64'h0807_0605_0403_0201) begin
            n_fail++;
            $display("FAIL stall_result: shifts=%0d chain=%h, required 64 0807060504030201",
                     a_shifts - s0, a_chain);
        end
    endtask

    task automatic test_reset_mid();
        int l0, s0;
        a_start_pulse();
        a_send(8'h11, 0);
        a_send(8'h22, 0);
        a_send(8'h33, 0);
        repeat (2) @(negedge clk);
        l0 = a_latches;
        reset = 1'b1;
        a_s_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({a_busy, a_done, a_shift_en, a_s_ready} !== 4'b0 || a_bit_cnt !== 7'd0) begin
            n_fail++;
            $display("FAIL midreset_state: busy=%b done=%b shift_en=%b s_ready=%b bit_cnt=%0d, required all 0",
                     a_busy, a_done, a_shift_en, a_s_ready, a_bit_cnt);
        end
        reset = 1'b0;
        repeat (12) @(negedge clk);
        n_checks++;
        if (a_latches - l0 !== 0 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_latch: latches=%0d busy=%b, required 0 0", a_latches - l0, a_busy);
        end
        s0 = a_shifts;
        a_program(64'hF0E1_D2C3_B4A5_9687, 0);
        n_checks++;
        if (a_done !== 1'b1 || a_shifts - s0 !== 64 || a_chain !== 64'hF0E1_D2C3_B4A5_9687) begin
            n_fail++;
            $display("FAIL midreset_reload: done=%b shifts=%0d chain=%h, required 1 64 f0e1d2c3b4a59687",
                     a_done, a_shifts - s0, a_chain);
        end
    endtask

    task automatic test_start_handling();
        logic [6:0] b;
        a_start_pulse();
        a_send(8'h11, 0);
        @(negedge clk);
        b = a_bit_cnt;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        n_checks++;
        if (a_bit_cnt !== b + 7'd1 || a_shift_en !== 1'b1 || a_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_in_shift: bit_cnt=%0d shift_en=%b busy=%b, required %0d 1 1",
                     a_bit_cnt, a_shift_en, a_busy, b + 7'd1);
        end
        for (int i = 2; i <= 8; i++) a_send(8'(i * 17), 0);
        a_s_valid = 1'b0;
        a_wait_done();
        n_checks++;
        if (a_done !== 1'b1 || a_bit_cnt !== 7'd64) begin
            n_fail++; $display("FAIL start_complete: done=%b bit_cnt=%0d, required 1 64", a_done, a_bit_cnt);
        end
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        n_checks++;
        if (a_done !== 1'b0 || a_s_ready !== 1'b1 || a_busy !== 1'b1 || a_bit_cnt !== 7'd0) begin
            n_fail++;
            $display("FAIL start_in_done: done=%b s_ready=%b busy=%b bit_cnt=%0d, required 0 1 1 0",
                     a_done, a_s_ready, a_busy, a_bit_cnt);
        end
        for (int i = 0; i < 8; i++) a_send(8'h5A, 0);
        a_s_valid = 1'b0;
        a_wait_done();
        n_checks++;
        if (a_done !== 1'b1 || a_chain !== {8{8'h5A}}) begin
            n_fail++; $display("FAIL restart_complete: done=%b chain=%h, required 1 5a5a5a5a5a5a5a5a", a_done, a_chain);
        end
    endtask

    task automatic test_partial();
        int s0, l0, r0, t;
        b_preload(20'hABCDE);
        s0 = b_shifts; l0 = b_latches; r0 = b_rd_q.size();
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        b_send(8'hFF);
        b_send(8'hFF);
        b_send(8'h3C);
        b_s_valid = 1'b0;
        t = 0;
        while (b_done !== 1'b1 && t < 500) begin @(negedge clk); t++; end
        n_checks++;
        if (b_shifts - s0 !== 20 || b_latches - l0 !== 1) begin
            n_fail++;
            $display("FAIL partial_counts: shifts=%0d latches=%0d, required 20 1", b_shifts - s0, b_latches - l0);
        end
        n_checks++;
        if (b_done !== 1'b1 || b_bit_cnt !== 5'd20) begin
            n_fail++; $display("FAIL partial_status: done=%b bit_cnt=%0d, required 1 20", b_done, b_bit_cnt);
        end
        n_checks++;
        if (b_chain !== 20'hCFFFF) begin
            n_fail++; $display("FAIL partial_chain: got %h, required cffff", b_chain);
        end
        n_checks++;
        if (b_rd_q.size() - r0 !== 3) begin
            n_fail++; $display("FAIL partial_rd_count: got %0d, required 3", b_rd_q.size() - r0);
        end else begin
            n_checks++;
            if (b_rd_q[r0] !== 8'hDE || b_rd_q[r0+1] !== 8'hBC || b_rd_q[r0+2] !== 8'h0A) begin
                n_fail++;
                $display("FAIL partial_rd_data: got %h %h %h, required de bc 0a",
                         b_rd_q[r0], b_rd_q[r0+1], b_rd_q[r0+2]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_readback();
        test_stall();
        test_reset_mid();
        test_start_handling();
        test_partial();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cfg_chain_ctrl.md
Name: cfg_chain_ctrl

Overview:
- Configuration-chain programming controller for hierarchically instantiated leaf cells whose config bits are daisy-chained through intermediate wrapper instances into one serial chain.
- Accepts parallel config words from a host stream and serializes them LSB-first into the chain head.
- Captures the bits exiting the chain tail as readback words.
- Issues a single latch pulse once exactly CHAIN_LEN bits have been shifted.

Parameters:
- WORD_W, 8, host word width in bits (>=2).
- CHAIN_LEN, 64, total config bits in the chain (>=1; need not be a multiple of WORD_W).
- CNT_W, clog2(CHAIN_LEN+1), bit-counter width (derived; do not override).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin programming.
- s_data  in  WORD_W  config word, bit 0 shifted first.
- s_valid  in  1  s_data valid.
- s_ready  out  1  controller accepts a word this cycle.
- cfg_shift_en  out  1  chain shift enable; the chain shifts on each clk edge where it is 1.
- cfg_dout  out  1  serial bit into the chain head.
- cfg_din  in  1  serial bit from the chain tail.
- cfg_latch  out  1  one-cycle pulse; leaf cells capture their config.
- rd_data  out  WORD_W  readback word (tail bits, first-out in bit 0).
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- busy  out  1  programming in progress.
- done  out  1  sticky completion flag.
- bit_cnt  out  CNT_W  bits shifted so far.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset values: all outputs 0; state IDLE; counters and shift registers cleared. Reset mid-operation aborts immediately. Chain contents are then undefined, and no cfg_latch is issued.
- All outputs are registered.
- States: IDLE, FETCH, SHIFT, LATCH, DONE.
- IDLE:
  - s_ready=0, busy=0.
  - start -> FETCH; bit_cnt<=0.
- FETCH:
  - s_ready=1, busy=1.
  - On s_valid: load s_data into the transmit register.
  - Set word_left = min(WORD_W, CHAIN_LEN-bit_cnt), then go to SHIFT.
  - Without s_valid: stay in FETCH with cfg_shift_en=0; the chain holds.
- SHIFT:
  - Each cycle: cfg_shift_en=1, cfg_dout = tx[0], tx shifts right, bit_cnt+1, word_left-1.
  - The first cfg_dout bit is presented in the cycle after the handshake. Minimum one-cycle bubble between words.
  - On each shifting edge, cfg_din is sampled into the receive register (LSB-first).
  - After the last bit of the word:
    - If bit_cnt reaches CHAIN_LEN -> LATCH.
    - Otherwise -> FETCH.
- Readback:
  - rd_valid pulses one cycle after each WORD_W received bits.
  - It also pulses after the final bit if a partial word is pending. A partial word is right-aligned, with unused upper bits 0.
- Partial last word: only the low (CHAIN_LEN mod WORD_W) bits of s_data are shifted; the rest are discarded.
- LATCH: cfg_latch=1 for exactly one cycle, cfg_shift_en=0 -> DONE.
- DONE:
  - done=1, busy=0, bit_cnt holds CHAIN_LEN.
  - start -> FETCH, with done cleared on the same edge.
- Ignored inputs:
  - start in FETCH, SHIFT or LATCH is ignored.
  - s_valid outside FETCH is ignored (s_ready=0).
- bit_cnt never exceeds CHAIN_LEN; no wrap-around.

Decomposition:
- Package cfg_chain_pkg: state enum (IDLE, FETCH, SHIFT, LATCH, DONE) and a clog2 function.
- One sub-module, cfg_word_serdes: the WORD_W transmit PISO and receive SIPO pair, with load, shift and clear controls and a partial-flush output.
- The FSM and counters stay in cfg_chain_ctrl.

Test Plan:
- Full load: WORD_W=8, CHAIN_LEN=64, words 0x01..0x08 with s_valid held high, 64-bit chain model -> exactly 64 cfg_shift_en cycles, one cfg_latch, done=1, bit_cnt=64, model holds the words in order.
- Readback: chain model preloaded with all 0xA5 bytes, then reprogrammed with 0x00s -> 8 rd_valid pulses, each rd_data=0xA5, then the model reads all zero.
- Partial word: CHAIN_LEN=20, words 0xFF, 0xFF, 0x3C -> 20 shifts; third word shifts bits 0,0,1,1; third rd_valid has rd_data[7:4]=0; single cfg_latch.
- Host stalls: 5-cycle s_valid gaps between words -> cfg_shift_en=0 throughout the gaps, total shifts still 64, chain content identical to the full-load case.
- Reset mid-shift: reset during the 3rd word -> next cycle busy=0, done=0, bit_cnt=0, cfg_shift_en=0, s_ready=0, no cfg_latch. A new start then completes a full 64-bit load.
- start handling: start pulsed during SHIFT -> no effect, bit_cnt continues. start in DONE -> done=0 and s_ready=1 next cycle.
